tinker_fetch_unit: RTL and testbench
====================================

Name: tinker_fetch_unit

Overview:
- Instruction-supply end of the tinker_core instruction interface.
- Fetches 32-bit instruction words from instruction memory at an incrementing 64-bit PC and buffers them in a small prefetch FIFO.
- Presents them to the decode stage with a valid/ready handshake.
- Supports PC redirect (branch/jump/return) with flush and discard of in-flight responses.

Parameters:
- RESET_PC, 64'h2000, PC loaded at reset; first fetch address.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- MAX_OUTSTANDING, 4, maximum memory requests issued but not yet answered.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request this cycle.
- mem_req_addr  output  64  byte address of requested instruction word.
- mem_resp_valid  input  1  response data valid. Responses return in request order, at most one per cycle, and cannot be back-pressured.
- mem_resp_data  input  32  instruction word.
- instr_valid  output  1  instr_data/instr_pc hold a valid instruction.
- instr_ready  input  1  decode stage consumes the instruction this cycle.
- instr_data  output  32  instruction word at the FIFO head.
- instr_pc  output  64  PC of instr_data.
- redirect_valid  input  1  redirect fetch stream this cycle.
- redirect_pc  input  64  new fetch PC; bits [1:0] are forced to 0.

Behaviour:
- Reset (async, reset_n low): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs: mem_req_valid=0, instr_valid=0, mem_req_addr=RESET_PC, instr_data=0, instr_pc=0. Reset mid-transaction abandons all in-flight requests; their late responses are not the block's concern (memory is reset together).
- Issue rule: mem_req_valid = !redirect_valid && (fifo_count + outstanding_live) < FIFO_DEPTH && outstanding < MAX_OUTSTANDING.
  - outstanding_live = outstanding - drop_cnt.
  - The credit rule guarantees the FIFO never overflows; no full-drop path exists.
- mem_req_addr = fetch_pc, combinationally.
- On request handshake (mem_req_valid && mem_req_ready): fetch_pc += 4 (mod 2^64), outstanding++.
- On response:
  - outstanding--.
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Otherwise push {mem_resp_data, resp_pc}, then resp_pc += 4.
- A response arriving with outstanding==0 is a protocol violation: ignored, no state change.
- Output:
  - instr_valid = fifo_count != 0.
  - instr_data/instr_pc come from the registered FIFO head; they show 0 when empty.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave the count unchanged.
- Latency: a request accepted in cycle N with its response in cycle N+k gives instr_valid in cycle N+k+1. Minimum 2 cycles, request to instr_valid.
- Redirect cycle:
  - No request is issued.
  - At the next edge: FIFO flushed (count=0), fetch_pc=resp_pc=redirect_pc&~3.
  - outstanding and drop_cnt are both set to outstanding minus (mem_resp_valid ? 1 : 0), so every in-flight response is discarded.
  - A pop or push in the redirect cycle is overridden by the flush.
  - Issue resumes the cycle after the redirect.
- Back-to-back redirects: the last one wins; drop accounting remains exact.
- Steady state with instr_ready=1, mem_req_ready=1 and 1-cycle memory: one instruction per cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Optional Feature:
- Macro: TINKER_FETCH_PERF_EN.
- When defined, adds three output ports, all reset to 0 and wrapping at 2^32:
  - perf_fetched (32): increments per instruction popped.
  - perf_stall (32): increments each cycle with instr_valid=0 and no redirect.
  - perf_redirects (32): increments per redirect cycle.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory always ready with 1-cycle latency, instr_ready=1 → requests at 0x2000, 0x2004, 0x2008…; instr_pc sequence 0x2000, 0x2004…; first instr_valid 2 cycles after the first request.
- instr_ready=0 with fast memory → exactly FIFO_DEPTH=4 requests issued, then mem_req_valid=0. Raise instr_ready → words pop in order 0x2000..0x200C and issue resumes at 0x2010.
- Memory latency 6 cycles → outstanding never exceeds 4; no response is lost; instr_pc stays contiguous.
- Redirect to 0x4003 while 3 requests are in flight → addr 0x4000 issued the cycle after redirect; the 3 stale responses are discarded; the first delivered instr_pc is 0x4000.
- Redirect in the same cycle as a response and as instr_ready=1 → that response is dropped; drop_cnt = outstanding-1; no stale instruction appears.
- reset_n pulsed low mid-stream, asynchronously between edges → instr_valid and mem_req_valid drop immediately; fetch restarts at 0x2000.

Source files
------------

// File: rtl/tinker_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// tinker_fetch_unit_if
//
// Purpose: groups the tinker fetch unit's bus signals into one bundle. It
// carries the instruction memory request/response channel, the decode-side
// valid/ready instruction channel and the redirect input.
//
// Signals:
//   mem_req_valid / mem_req_ready / mem_req_addr   fetch request channel
//   mem_resp_valid / mem_resp_data                 in-order response channel
//                                                  (cannot be back-pressured)
//   instr_valid / instr_ready / instr_data / instr_pc  decode handshake
//   redirect_valid / redirect_pc                   fetch stream redirect
//
// Modports:
//   master : the fetch unit side
//   slave  : the environment side (memory, decode and branch logic)
// ---------------------------------------------------------------------------
interface tinker_fetch_unit_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [63:0] instr_pc;

  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/tinker_fetch_unit.sv
// ---------------------------------------------------------------------------
// tinker_fetch_unit
//
// Purpose: instruction-supply end of the tinker_core instruction interface.
// It fetches 32-bit instruction words at an incrementing 64-bit PC, buffers
// them in a small prefetch FIFO and hands them to decode with valid/ready.
// A redirect flushes the FIFO, restarts fetch at the new PC and discards
// every response that is still in flight.
//
// Parameters:
//   RESET_PC        first fetch address after reset
//   FIFO_DEPTH      prefetch FIFO entries (power of two, >= 2)
//   MAX_OUTSTANDING maximum requests issued but not yet answered
//
// Ports:
//   clk      core clock, all state updates on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      tinker_fetch_unit_if.master (memory, decode, redirect)
//
// Optional feature (define TINKER_FETCH_PERF_EN):
//   perf_fetched    instructions popped by decode
//   perf_stall      cycles with no valid instruction and no redirect
//   perf_redirects  redirect cycles
//   All three are 32-bit, reset to 0 and wrap.
// ---------------------------------------------------------------------------
module tinker_fetch_unit #(
  parameter logic [63:0] RESET_PC        = 64'h2000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  tinker_fetch_unit_if.master bus
`ifdef TINKER_FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall,
  output logic [31:0]         perf_redirects
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [63:0]      resp_pc_q,  resp_pc_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [OUT_W-1:0] outst_q,    outst_d;
  logic [OUT_W-1:0] drop_q,     drop_d;

  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [63:0]      fifo_pc_q   [FIFO_DEPTH];

  logic [31:0]      live_cnt;
  logic             req_valid;
  logic             req_fire;
  logic             resp_ok;
  logic             push;
  logic             pop;
  logic             fifo_valid;

  // Credit accounting: FIFO entries plus responses that will still be kept
  // must leave room, so a returning response always finds a free slot.
  assign live_cnt   = 32'(count_q) + 32'(outst_q) - 32'(drop_q);
  assign req_valid  = reset_n && !bus.redirect_valid &&
                      (live_cnt < 32'(FIFO_DEPTH)) &&
                      (32'(outst_q) < 32'(MAX_OUTSTANDING));
  assign req_fire   = req_valid && bus.mem_req_ready;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign resp_ok    = bus.mem_resp_valid && (outst_q != '0);
  assign push       = resp_ok && (drop_q == '0);
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && bus.instr_ready;

  // Next-state logic. A redirect overrides any push or pop in its cycle and
  // marks every response still owed by memory (minus the one arriving now)
  // as one to discard.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~64'h3;
      resp_pc_d  = bus.redirect_pc & ~64'h3;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      outst_d    = outst_q - OUT_W'(resp_ok);
      drop_d     = outst_q - OUT_W'(resp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      outst_d = outst_q + OUT_W'(req_fire) - OUT_W'(resp_ok);
      if (resp_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - OUT_W'(1);
        end else begin
          resp_pc_d = resp_pc_q + 64'd4;
          wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while count_q
  // covers them. A write in a redirect cycle lands in a slot the flush
  // has already invalidated.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.mem_resp_data;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.instr_valid   = fifo_valid;
  assign bus.instr_data    = fifo_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign bus.instr_pc      = fifo_valid ? fifo_pc_q[rd_ptr_q]   : 64'h0;

`ifdef TINKER_FETCH_PERF_EN
  // Performance counters. A pop in a redirect cycle is cancelled by the
  // flush, so it does not count as fetched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched   <= '0;
      perf_stall     <= '0;
      perf_redirects <= '0;
    end else begin
      if (pop && !bus.redirect_valid) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (!fifo_valid && !bus.redirect_valid) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (bus.redirect_valid) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_tinker_fetch_unit
//
// Self-checking bench for tinker_fetch_unit. A behavioural memory returns
// words in order after a random latency; the word for an address is a fixed
// function of the address, so every delivered instruction can be matched to
// its PC. The reference model tracks transactions (requests in flight,
// responses that will be kept, instructions waiting for decode) rather than
// the design's registers.
// ---------------------------------------------------------------------------
module tb_tinker_fetch_unit;

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          epoch;
  } req_t;

  logic clk = 1'b0;
  logic reset_n;

  // 10 ns core clock.
  always #5 clk = ~clk;

  tinker_fetch_unit_if bus ();

`ifdef TINKER_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_redirects;
`endif

  tinker_fetch_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef TINKER_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_redirects (perf_redirects)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc;
  req_t        pend[$];
  int          lastDue;
  int          epoch;
  int          live;
  int          arrived;
  int          delivered;
  int          reqCount;
  int          firstReqCyc;
  int          firstValidCyc;
  logic [63:0] expReqAddr;
  logic [63:0] expPc;
  bit          awaitFirst;
  logic [63:0] firstAfterRedir;

  int          latMin, latMax, readyPct, instrPct, redirPermille;
  bit          forceRedir;
  bit          redirOnResp;
  logic [63:0] forcePc;

  // Instruction word stored at a given address.
  function automatic logic [31:0] wordAt(input logic [63:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF ^ a[47:16];
  endfunction

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic driveIdle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
  endtask

  // Memory and model restart together with the design.
  task automatic clearModel();
    pend.delete();
    lastDue         = -1;
    epoch           = 0;
    live            = 0;
    arrived         = 0;
    delivered       = 0;
    reqCount        = 0;
    firstReqCyc     = -1;
    firstValidCyc   = -1;
    expReqAddr      = 64'h2000;
    expPc           = 64'h2000;
    awaitFirst      = 1'b0;
    firstAfterRedir = 64'h0;
    cyc             = 0;
  endtask

  // Asserts reset between clock edges, checks that the outputs drop at
  // once, then releases reset between edges.
  task automatic applyReset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    driveIdle();
    #1;
    checkOutput("reset_mem_req_valid", 64'(bus.mem_req_valid), 64'h0);
    checkOutput("reset_instr_valid",   64'(bus.instr_valid),   64'h0);
    checkOutput("reset_mem_req_addr",  bus.mem_req_addr,       64'h2000);
    checkOutput("reset_instr_pc",      bus.instr_pc,           64'h0);
    checkOutput("reset_instr_data",    64'(bus.instr_data),    64'h0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    clearModel();
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs 1 ns
  // later, then advance the model as the rising edge will.
  task automatic applyStimulus();
    req_t        r;
    bit          respNow;
    int          respEpoch;
    logic [63:0] respAddr;
    bit          redir;
    logic [63:0] rpc;
    bit          rdy, irdy;
    bit          expReqV, expInstrV;
    int          due;

    @(negedge clk);
    respNow   = 1'b0;
    respEpoch = -1;
    respAddr  = 64'h0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r         = pend.pop_front();
      respNow   = 1'b1;
      respAddr  = r.addr;
      respEpoch = r.epoch;
    end
    rdy       = (int'($urandom_range(99)) < readyPct);
    irdy      = (int'($urandom_range(99)) < instrPct);
    expInstrV = (arrived > 0);
    redir     = forceRedir || (int'($urandom_range(999)) < redirPermille) ||
                (redirOnResp && respNow && expInstrV);
    if (forceRedir || redirOnResp)
      rpc = forcePc;
    else if ($urandom_range(1) == 1)
      rpc = {32'h0000_0001, $urandom()};
    else
      rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31));
    if (redir) redirOnResp = 1'b0;

    bus.mem_req_ready  = rdy;
    bus.mem_resp_valid = respNow;
    bus.mem_resp_data  = respNow ? wordAt(respAddr) : $urandom();
    bus.instr_ready    = irdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;

    expReqV = !redir && (live < 4) && ((pend.size() + (respNow ? 1 : 0)) < 4);
    checkOutput("mem_req_valid", 64'(bus.mem_req_valid), 64'(expReqV));
    if (expReqV) checkOutput("mem_req_addr", bus.mem_req_addr, expReqAddr);
    checkOutput("instr_valid", 64'(bus.instr_valid), 64'(expInstrV));
    if (expInstrV) begin
      checkOutput("instr_pc",   bus.instr_pc,          expPc);
      checkOutput("instr_data", 64'(bus.instr_data),   64'(wordAt(expPc)));
    end else begin
      checkOutput("instr_pc_empty",   bus.instr_pc,        64'h0);
      checkOutput("instr_data_empty", 64'(bus.instr_data), 64'h0);
    end

    if (expInstrV && firstValidCyc < 0) firstValidCyc = cyc;
    if (redir) begin
      epoch++;
      live       = 0;
      arrived    = 0;
      expReqAddr = rpc & ~64'h3;
      expPc      = rpc & ~64'h3;
      awaitFirst = 1'b1;
    end else begin
      if (expReqV && rdy) begin
        due = cyc + int'($urandom_range(latMax, latMin));
        if (due <= lastDue) due = lastDue + 1;
        r.addr  = expReqAddr;
        r.due   = due;
        r.epoch = epoch;
        pend.push_back(r);
        lastDue    = due;
        expReqAddr = expReqAddr + 64'd4;
        live++;
        if (firstReqCyc < 0) firstReqCyc = cyc;
        reqCount++;
      end
      if (respNow && respEpoch == epoch) arrived++;
      if (expInstrV && irdy) begin
        if (awaitFirst) begin
          firstAfterRedir = expPc;
          awaitFirst      = 1'b0;
        end
        arrived--;
        live--;
        expPc = expPc + 64'd4;
        delivered++;
      end
    end
    cyc++;
  endtask

  task automatic setMode(input int lmin, input int lmax, input int rp,
                         input int ip, input int redp);
    latMin        = lmin;
    latMax        = lmax;
    readyPct      = rp;
    instrPct      = ip;
    redirPermille = redp;
    forceRedir    = 1'b0;
    redirOnResp   = 1'b0;
    forcePc       = 64'h0;
  endtask

  // Directed phases followed by a randomized soak with a mid-stream reset.
  initial begin
    reset_n = 1'b0;
    driveIdle();
    clearModel();
    setMode(1, 1, 100, 100, 0);

    // Fast memory, decode always ready: one instruction per cycle.
    applyReset();
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("first_request_cycle", 64'(firstReqCyc), 64'h0);
    checkOutput("first_valid_latency", 64'(firstValidCyc - firstReqCyc), 64'd2);
    checkOutput("steady_throughput",   64'(delivered), 64'd18);

    // Decode stalled: exactly FIFO_DEPTH requests, then drain in order.
    applyReset();
    setMode(1, 1, 100, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("stall_request_count", 64'(reqCount), 64'd4);
    instrPct = 100;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("stall_drain_issue_resumed", 64'(reqCount > 4), 64'h1);
    checkOutput("stall_drain_delivered",     64'(delivered >= 4), 64'h1);

    // Slow memory: outstanding limit and contiguous PCs.
    applyReset();
    setMode(6, 6, 100, 100, 0);
    for (int i = 0; i < 60; i++) applyStimulus();
    checkOutput("slow_mem_delivered", 64'(delivered >= 20), 64'h1);

    // Redirect to 0x4003 with three requests in flight.
    applyReset();
    setMode(6, 6, 100, 100, 0);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("inflight_before_redirect", 64'(pend.size()), 64'd3);
    forceRedir = 1'b1;
    forcePc    = 64'h4003;
    applyStimulus();
    forceRedir = 1'b0;
    applyStimulus();
    checkOutput("redirect_next_issue", 64'(reqCount), 64'd4);
    for (int i = 0; i < 25; i++) applyStimulus();
    checkOutput("first_after_redirect", firstAfterRedir, 64'h4000);

    // Redirect coinciding with a response and a pop.
    applyReset();
    setMode(2, 2, 100, 100, 0);
    forcePc     = 64'h8000;
    redirOnResp = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("resp_redirect_taken",       64'(redirOnResp), 64'h0);
    checkOutput("resp_redirect_first_pc",    firstAfterRedir, 64'h8000);

    // Randomized soak with an asynchronous reset in the middle.
    applyReset();
    setMode(1, 5, 70, 60, 30);
    for (int i = 0; i < 800; i++) applyStimulus();
    checkOutput("random_delivered_a", 64'(delivered > 0), 64'h1);
    applyReset();
    for (int i = 0; i < 800; i++) applyStimulus();
    checkOutput("random_delivered_b", 64'(delivered > 0), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
